mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Sits directly downstream of the single-cycle datapath and merges its instruction-cache refill port and its data-memory port onto one shared memory bus.
- The instruction-cache refill port is the level request o_IC_DataReq / o_IM_Addr, answered by i_IC_MemReady / i_IM_Instr.
- The data-memory port is o_DM_Wen / o_DM_MemRead / o_DM_Addr / o_DM_Wd / o_DM_f3, answered by i_DM_data_ready / i_DM_ReadData.
- Arbitrates between the two requesters, drives one transaction at a time, returns read data and a registered ready pulse, and bounds each transaction with a timeout.

Parameters:
- TIMEOUT, 255: bus cycles to wait for i_MEM_ready before aborting the transaction; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_ic_req  in  1  instruction refill request (level).
- i_ic_addr  in  32  instruction fetch address.
- o_ic_ready  out  1  one-cycle pulse: instruction transaction complete.
- o_ic_rdata  out  32  instruction word; valid while o_ic_ready is high.
- i_dm_wen  in  1  data write request (level).
- i_dm_ren  in  1  data read request (level).
- i_dm_addr  in  32  data address.
- i_dm_wd  in  32  write data.
- i_dm_f3  in  3  funct3 access size/sign, forwarded unchanged.
- o_dm_ready  out  1  one-cycle pulse: data transaction complete.
- o_dm_rdata  out  32  read data; valid while o_dm_ready is high.
- o_mem_req  out  1  bus request, held until accepted.
- o_mem_wen  out  1  bus write enable.
- o_mem_addr  out  32  bus address.
- o_mem_wd  out  32  bus write data.
- o_mem_f3  out  3  bus access size.
- i_mem_ready  in  1  bus completion strobe.
- i_mem_rdata  in  32  bus read data; valid while i_mem_ready is high.
- o_bus_err  out  1  one-cycle pulse coincident with the ready pulse when the transaction timed out.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - state=IDLE, last_grant=IC, counter=0.
  - All outputs 0, including o_ic_rdata, o_dm_rdata and o_mem_*.
- A reset asserted mid-transaction abandons the transaction immediately. A later i_mem_ready is ignored while in IDLE.
- FSM states: IDLE, IC_BUS, DM_BUS, RESP.
- IDLE:
  - dm_req = i_dm_wen | i_dm_ren.
  - If only dm_req is high, go to DM_BUS.
  - If only i_ic_req is high, go to IC_BUS.
  - If both are high, grant the requester that is not last_grant. At reset this means DM wins the first conflict. Update last_grant on every grant.
  - At the granting edge, register the bus outputs from the winner:
    - IC: o_mem_wen=0, o_mem_f3=3'b010, o_mem_wd=0.
    - DM: o_mem_wen=i_dm_wen; i_dm_wen has precedence if both i_dm_wen and i_dm_ren are set.
- IC_BUS / DM_BUS:
  - o_mem_req=1. Bus outputs are held stable and are not re-sampled from the requesters.
  - The counter increments each cycle.
  - If i_mem_ready=1: capture i_mem_rdata into the granted rdata register (a write returns 0), then go to RESP.
  - Else if TIMEOUT≠0 and counter==TIMEOUT-1: rdata=0, set the error flag, go to RESP.
- RESP:
  - Exactly one cycle: o_mem_req=0; the granted ready is 1; o_bus_err=flag.
  - The counter and flag are cleared, then the FSM returns to IDLE.
- Minimum transaction: 3 cycles from request sampled to ready pulse, for a 1-cycle bus. Requests are re-sampled only in IDLE, so a requester that drops its request after its ready pulse is never served twice.
- The ready/rdata of the non-granted side stay 0. The rdata registers hold their value outside RESP, but are defined only while ready is high.
- Requests that change while not in IDLE are ignored until the next IDLE.
- An i_mem_ready arriving in IDLE or RESP is ignored.

Test Plan:
- IC-only read: i_ic_req=1, addr 0x0000_0100; bus returns 0x0000_0013 one cycle after o_mem_req → o_mem_addr=0x100, o_mem_wen=0, o_mem_f3=010; o_ic_ready pulses once with o_ic_rdata=0x13; o_dm_ready stays 0.
- DM write: i_dm_wen=1, addr 0x2000, wd 0xDEADBEEF, f3=000 → bus shows wen=1, the same address/data/f3, and a single o_dm_ready pulse.
- Simultaneous requests from reset, each held until its ready → the DM transaction is served first, then the IC transaction. With both held continuously, grants alternate DM, IC, DM, IC.
- Timeout: TIMEOUT=4, i_mem_ready held 0 → after 4 bus cycles, o_ic_ready=1, o_bus_err=1, rdata=0; the FSM returns to IDLE.
- Reset mid-DM_BUS → all outputs 0 next cycle; a stray i_mem_ready afterwards produces no ready pulse.
- Back-to-back IC requests, request re-asserted the cycle after its ready pulse → exactly one bus transaction per request, 3-cycle spacing with a zero-wait bus.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Merges the instruction-cache refill port and the data-memory
//            port onto one shared memory bus. One transaction is in flight at
//            a time. Conflicting requests are granted alternately, starting
//            with the data port. Each transaction ends with a one-cycle ready
//            pulse and is bounded by a timeout.
// Ports    : i_clk/i_rst           clock, synchronous active-high reset
//            i_ic_*/o_ic_*         instruction refill request / response
//            i_dm_*/o_dm_*         data read-write request / response
//            o_mem_*/i_mem_*       shared memory bus
//            o_bus_err             timeout flag, coincident with ready pulse
// Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255,  // 0 disables the timeout
  parameter int CNT_W   = 8     // 2**CNT_W must exceed TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ic_req,
  input  logic [31:0] i_ic_addr,
  output logic        o_ic_ready,
  output logic [31:0] o_ic_rdata,
  input  logic        i_dm_wen,
  input  logic        i_dm_ren,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wd,
  input  logic [2:0]  i_dm_f3,
  output logic        o_dm_ready,
  output logic [31:0] o_dm_rdata,
  output logic        o_mem_req,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic [2:0]  o_mem_f3,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IC_BUS = 2'd1,
    S_DM_BUS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic             C_GRANT_IC  = 1'b0;
  localparam logic             C_GRANT_DM  = 1'b1;
  localparam logic [CNT_W-1:0] C_TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]       C_IC_F3     = 3'b010;

  state_t            state_q, state_d;
  // Holds the owner of the current transaction from grant through RESP, and
  // afterwards remembers who went last for the alternating priority.
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              mem_wen_q, mem_wen_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wd_q, mem_wd_d;
  logic [2:0]        mem_f3_q, mem_f3_d;
  logic [31:0]       ic_rdata_q, ic_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;

  logic              w_dm_req;
  assign w_dm_req = i_dm_wen | i_dm_ren;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= C_GRANT_IC;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
      mem_f3_q     <= '0;
      ic_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wd_q     <= mem_wd_d;
      mem_f3_q     <= mem_f3_d;
      ic_rdata_q   <= ic_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wd_d     = mem_wd_q;
    mem_f3_d     = mem_f3_q;
    ic_rdata_d   = ic_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    case (state_q)
      S_IDLE: begin
        // On a conflict the side that did not win last time is served.
        if (w_dm_req && (!i_ic_req || (last_grant_q == C_GRANT_IC))) begin
          state_d      = S_DM_BUS;
          last_grant_d = C_GRANT_DM;
          mem_wen_d    = i_dm_wen;  // write wins if both enables are set
          mem_addr_d   = i_dm_addr;
          mem_wd_d     = i_dm_wd;
          mem_f3_d     = i_dm_f3;
        end else if (i_ic_req) begin
          state_d      = S_IC_BUS;
          last_grant_d = C_GRANT_IC;
          mem_wen_d    = 1'b0;
          mem_addr_d   = i_ic_addr;
          mem_wd_d     = '0;
          mem_f3_d     = C_IC_F3;
        end
      end

      S_IC_BUS, S_DM_BUS: begin
        cnt_d = cnt_q + 1'b1;
        if (i_mem_ready) begin
          if (state_q == S_IC_BUS) begin
            ic_rdata_d = i_mem_rdata;
          end else begin
            dm_rdata_d = mem_wen_q ? 32'd0 : i_mem_rdata;
          end
          state_d = S_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == C_TMO_LAST)) begin
          if (state_q == S_IC_BUS) begin
            ic_rdata_d = '0;
          end else begin
            dm_rdata_d = '0;
          end
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // All outputs decode registered state, so the ready pulses are glitch-free
  // and every output is zero straight out of reset.
  assign o_mem_req  = (state_q == S_IC_BUS) || (state_q == S_DM_BUS);
  assign o_ic_ready = (state_q == S_RESP) && (last_grant_q == C_GRANT_IC);
  assign o_dm_ready = (state_q == S_RESP) && (last_grant_q == C_GRANT_DM);
  assign o_bus_err  = (state_q == S_RESP) && err_q;
  assign o_mem_wen  = mem_wen_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_wd   = mem_wd_q;
  assign o_mem_f3   = mem_f3_q;
  assign o_ic_rdata = ic_rdata_q;
  assign o_dm_rdata = dm_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed testbench for mem_bus_arbiter with a scoreboard of
//            expected transactions, a bus responder of programmable latency
//            and a monitor that checks bus launches and ready pulses.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ready;
  logic [31:0] ic_rdata;
  logic        dm_wen, dm_ren;
  logic [31:0] dm_addr, dm_wd;
  logic [2:0]  dm_f3;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_wen;
  logic [31:0] mem_addr, mem_wd;
  logic [2:0]  mem_f3;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ic_req(ic_req), .i_ic_addr(ic_addr),
    .o_ic_ready(ic_ready), .o_ic_rdata(ic_rdata),
    .i_dm_wen(dm_wen), .i_dm_ren(dm_ren), .i_dm_addr(dm_addr),
    .i_dm_wd(dm_wd), .i_dm_f3(dm_f3),
    .o_dm_ready(dm_ready), .o_dm_rdata(dm_rdata),
    .o_mem_req(mem_req), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
    .o_mem_wd(mem_wd), .o_mem_f3(mem_f3),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_bus_err(bus_err)
  );

  typedef struct {
    bit          dm;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  txn_t q[$];

  int tests      = 0;
  int fails      = 0;
  int cyc        = 0;
  int ready_cnt  = 0;
  int ready_cyc  = 0;
  int bus_starts = 0;
  int lat        = 1;    // responder latency in bus cycles, 0 = never answers
  bit stray      = 1'b0; // drive i_mem_ready while no request is pending

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : {a[15:0], ~a[15:0]};
  endfunction

  task automatic push_ic(input logic [31:0] a, input logic [31:0] rd, input logic e);
    txn_t t;
    t.dm = 1'b0; t.wen = 1'b0; t.addr = a; t.wd = '0; t.f3 = 3'b010;
    t.rdata = rd; t.err = e;
    q.push_back(t);
  endtask

  task automatic push_dm(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, input logic [31:0] rd, input logic e);
    txn_t t;
    t.dm = 1'b1; t.wen = w; t.addr = a; t.wd = d; t.f3 = f;
    t.rdata = rd; t.err = e;
    q.push_back(t);
  endtask

  // Bus responder: answers lat cycles into each transaction.
  initial begin
    int bus_cyc;
    bus_cyc = 0;
    forever begin
      @(negedge clk);
      if (mem_req) bus_cyc++;
      else bus_cyc = 0;
      if (mem_req && (lat > 0) && (bus_cyc == lat)) begin
        mem_ready = 1'b1;
        mem_rdata = rd_of(mem_addr);
      end else begin
        mem_ready = stray;
        mem_rdata = stray ? 32'hFFFF_FFFF : 32'h0;
      end
    end
  end

  // Monitor: checks bus launches against the queue head, pops on ready.
  initial begin
    logic prev_req;
    txn_t t;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_req && !prev_req) begin
        bus_starts++;
        if (q.size() == 0) chk("spurious_req", mem_req, 1'b0);
        else begin
          chk("bus_wen",  mem_wen,  q[0].wen);
          chk("bus_addr", mem_addr, q[0].addr);
          chk("bus_wd",   mem_wd,   q[0].wd);
          chk("bus_f3",   mem_f3,   q[0].f3);
        end
      end
      prev_req = mem_req;
      if (ic_ready || dm_ready) begin
        ready_cnt++;
        ready_cyc = cyc;
        if (q.size() == 0) chk("spurious_ready", {ic_ready, dm_ready}, 2'b00);
        else begin
          t = q.pop_front();
          chk("ready_side", {ic_ready, dm_ready}, t.dm ? 2'b01 : 2'b10);
          chk("rdata", t.dm ? dm_rdata : ic_rdata, t.rdata);
          chk("bus_err", bus_err, t.err);
        end
      end else if (bus_err) begin
        chk("stray_bus_err", bus_err, 1'b0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int target);
    int n;
    n = 0;
    while ((ready_cnt < target) && (n < 60)) begin
      step();
      n++;
    end
    if (ready_cnt < target) chk("wait_ready_timeout", ready_cnt, target);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {ic_ready, dm_ready, mem_req, mem_wen, bus_err}, 5'b0);
    chk({tag, "_ic_rdata"}, ic_rdata, 32'h0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wd"},   mem_wd,   32'h0);
    chk({tag, "_mem_f3"},   mem_f3,   3'h0);
  endtask

  initial begin
    int t0, r1, r2, base;
    rst = 1'b1; ic_req = 0; ic_addr = 0;
    dm_wen = 0; dm_ren = 0; dm_addr = 0; dm_wd = 0; dm_f3 = 0;
    repeat (3) step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    // IC-only read
    push_ic(32'h100, 32'h13, 1'b0);
    ic_req = 1; ic_addr = 32'h100; t0 = cyc;
    wait_ready(ready_cnt + 1);
    ic_req = 0;
    chk("ic_latency", ready_cyc - t0, 2);
    step(); step();

    // DM write: read data returned on the bus must be suppressed
    push_dm(1'b1, 32'h2000, 32'hDEADBEEF, 3'b000, 32'h0, 1'b0);
    dm_wen = 1; dm_addr = 32'h2000; dm_wd = 32'hDEADBEEF; dm_f3 = 3'b000;
    wait_ready(ready_cnt + 1);
    dm_wen = 0;
    step(); step();

    // Simultaneous requests from reset: DM first, then IC
    rst = 1; step(); step(); rst = 0;
    push_dm(1'b0, 32'h3000, 32'h0, 3'b100, rd_of(32'h3000), 1'b0);
    push_ic(32'h104, rd_of(32'h104), 1'b0);
    dm_ren = 1; dm_addr = 32'h3000; dm_wd = 0; dm_f3 = 3'b100;
    ic_req = 1; ic_addr = 32'h104;
    base = ready_cnt;
    wait_ready(base + 1);
    dm_ren = 0;
    wait_ready(base + 2);
    ic_req = 0;
    step(); step();

    // Both held continuously: DM, IC, DM, IC
    push_dm(1'b0, 32'h3100, 32'h0, 3'b010, rd_of(32'h3100), 1'b0);
    push_ic(32'h108, rd_of(32'h108), 1'b0);
    push_dm(1'b0, 32'h3100, 32'h0, 3'b010, rd_of(32'h3100), 1'b0);
    push_ic(32'h108, rd_of(32'h108), 1'b0);
    dm_ren = 1; dm_addr = 32'h3100; dm_f3 = 3'b010;
    ic_req = 1; ic_addr = 32'h108;
    wait_ready(ready_cnt + 4);
    dm_ren = 0; ic_req = 0;
    step(); step();

    // Timeout: bus never answers
    lat = 0;
    push_ic(32'h200, 32'h0, 1'b1);
    ic_req = 1; ic_addr = 32'h200; t0 = cyc;
    wait_ready(ready_cnt + 1);
    ic_req = 0;
    chk("timeout_latency", ready_cyc - t0, 5);
    step(); step();

    // Reset in the middle of a DM transaction, then a stray bus ready
    push_dm(1'b0, 32'h4000, 32'h0, 3'b001, 32'h0, 1'b0);
    dm_ren = 1; dm_addr = 32'h4000; dm_f3 = 3'b001;
    step(); step();
    chk("mid_busy", mem_req, 1'b1);
    rst = 1; dm_ren = 0; q.delete();
    step();
    chk_zero("midreset");
    rst = 0;
    base = ready_cnt;
    stray = 1'b1;
    repeat (3) step();
    stray = 1'b0;
    step();
    chk("stray_ready_count", ready_cnt, base);
    lat = 1;
    step();

    // Back-to-back IC requests, re-asserted the cycle after each ready
    base = bus_starts;
    push_ic(32'h300, rd_of(32'h300), 1'b0);
    ic_req = 1; ic_addr = 32'h300;
    wait_ready(ready_cnt + 1);
    r1 = ready_cyc; ic_req = 0;
    step();
    push_ic(32'h304, rd_of(32'h304), 1'b0);
    ic_req = 1; ic_addr = 32'h304;
    wait_ready(ready_cnt + 1);
    r2 = ready_cyc; ic_req = 0;
    chk("b2b_spacing1", r2 - r1, 3);
    step();
    push_ic(32'h308, rd_of(32'h308), 1'b0);
    ic_req = 1; ic_addr = 32'h308;
    wait_ready(ready_cnt + 1);
    r1 = ready_cyc; ic_req = 0;
    chk("b2b_spacing2", r1 - r2, 3);
    repeat (4) step();
    chk("b2b_bus_txns", bus_starts - base, 3);
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
